// File: rtl/us_pkg.sv
// +----------------------------------------------------------------------+
// | us_pkg : shared state encoding and 27 MHz / 40 kHz carrier defaults    |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package us_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int US_PERIOD_27M = 675;
  localparam int US_HALF_27M   = 337;
  localparam int US_DEAD_27M   = 14;
  localparam int US_CNT_W      = 16;

endpackage

`default_nettype wire

// File: rtl/us_burst_if.sv
// +----------------------------------------------------------------------+
// | us_burst_if : command/status and half-bridge drive bundle              |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface us_burst_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] burst_cycles;
  logic [CNT_W-1:0] gap_cycles;
  logic             continuous;
  logic             busy;
  logic             carrier_tick;
  logic             ch_a;
  logic             ch_b;

  modport master (
    output start, stop, burst_cycles, gap_cycles, continuous,
    input  busy, carrier_tick, ch_a, ch_b
  );

  modport slave (
    input  start, stop, burst_cycles, gap_cycles, continuous,
    output busy, carrier_tick, ch_a, ch_b
  );
endinterface

`default_nettype wire

// File: rtl/us_carrier_phase.sv
// +----------------------------------------------------------------------+
// | us_carrier_phase : carrier phase counter, parked at 0 while not run   |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module us_carrier_phase
  import us_pkg::*;
#(
  parameter int PERIOD = US_PERIOD_27M,
  parameter int PH_W   = $clog2(US_PERIOD_27M)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [PH_W-1:0] phase,
  output logic            wrap
);
  localparam logic [PH_W-1:0] LAST = PH_W'(PERIOD - 1);

  logic [PH_W-1:0] phase_q;
  logic [PH_W-1:0] phase_d;

  assign wrap  = run && (phase_q == LAST);
  assign phase = phase_q;

  always_comb begin
    phase_d = '0;
    if (run && !wrap) begin
      phase_d = phase_q + PH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/us_burst_driver.sv
// +----------------------------------------------------------------------+
// | us_burst_driver : gated, cycle-counted carrier bursts with dead time  |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module us_burst_driver
  import us_pkg::*;
#(
  parameter int PERIOD = US_PERIOD_27M,
  parameter int HALF   = US_HALF_27M,
  parameter int DEAD   = US_DEAD_27M,
  parameter int CNT_W  = US_CNT_W
) (
  input  logic      clk,
  input  logic      rst,
  us_burst_if.slave bus
);
  localparam int PH_W = $clog2(PERIOD);
  localparam logic [PH_W-1:0]  A_ON  = PH_W'(DEAD);
  localparam logic [PH_W-1:0]  A_OFF = PH_W'(HALF);
  localparam logic [PH_W-1:0]  B_ON  = PH_W'(HALF + DEAD);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  if (!(DEAD > 0 && DEAD < HALF)) begin : g_chk_dead_half
    $error("DEAD must satisfy 0 < DEAD < HALF");
  end
  if (!(DEAD < PERIOD - HALF)) begin : g_chk_dead_neg
    $error("DEAD must be shorter than the negative half");
  end
  if (PERIOD >= (1 << $clog2(PERIOD + 1))) begin : g_chk_period
    $error("PERIOD does not fit the phase counter");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             cont_q, cont_d;
  logic             ch_a_q, ch_a_d;
  logic             ch_b_q, ch_b_d;
  logic             tick_q, tick_d;
  logic             run;
  logic             wrap;
  logic [PH_W-1:0]  phase;

  // Dropping run on stop parks the phase at 0 on the very next edge.
  assign run = (state_q != IDLE) && !bus.stop;

  us_carrier_phase #(
    .PERIOD (PERIOD),
    .PH_W   (PH_W)
  ) u_phase (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .phase (phase),
    .wrap  (wrap)
  );

  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    gap_d    = gap_q;
    cont_d   = cont_q;
    remain_d = remain_q;
    ch_a_d   = (state_q == BURST) && (phase >= A_ON) && (phase < A_OFF);
    ch_b_d   = (state_q == BURST) && (phase >= B_ON);
    tick_d   = wrap;

    case (state_q)
      IDLE: begin
        if (bus.start && (bus.burst_cycles != '0)) begin
          state_d  = BURST;
          burst_d  = bus.burst_cycles;
          gap_d    = bus.gap_cycles;
          cont_d   = bus.continuous;
          remain_d = bus.burst_cycles;
        end
      end
      BURST: begin
        if (wrap) begin
          if (remain_q == ONE) begin
            if (gap_q != '0) begin
              state_d  = GAP;
              remain_d = gap_q;
            end else if (cont_q) begin
              remain_d = burst_q;
            end else begin
              state_d = IDLE;
            end
          end else begin
            remain_d = remain_q - ONE;
          end
        end
      end
      GAP: begin
        if (wrap) begin
          if (remain_q == ONE) begin
            if (cont_q) begin
              state_d  = BURST;
              remain_d = burst_q;
            end else begin
              state_d = IDLE;
            end
          end else begin
            remain_d = remain_q - ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.stop) begin
      state_d  = IDLE;
      remain_d = '0;
      ch_a_d   = 1'b0;
      ch_b_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      burst_q  <= '0;
      gap_q    <= '0;
      cont_q   <= 1'b0;
      remain_q <= '0;
      ch_a_q   <= 1'b0;
      ch_b_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      gap_q    <= gap_d;
      cont_q   <= cont_d;
      remain_q <= remain_d;
      ch_a_q   <= ch_a_d;
      ch_b_q   <= ch_b_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.carrier_tick = tick_q;
  assign bus.ch_a         = ch_a_q;
  assign bus.ch_b         = ch_b_q;

endmodule

`default_nettype wire

// File: tb/tb_us_burst_driver.sv
// +----------------------------------------------------------------------+
// | tb_us_burst_driver : timeline model of burst/gap schedule vs the DUT  |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_us_burst_driver;
  localparam int P = 10;
  localparam int H = 5;
  localparam int D = 1;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  us_burst_if #(.CNT_W(W)) bus ();

  us_burst_driver #(
    .PERIOD (P),
    .HALF   (H),
    .DEAD   (D),
    .CNT_W  (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_vec   = 0;
  int   n_err   = 0;
  int   cyc     = 0;
  int   base    = -100000;
  bit   m_act   = 1'b0;
  int   m_s     = 0;
  int   m_b     = 0;
  int   m_g     = 0;
  bit   m_cont  = 1'b0;
  logic prev_a  = 1'b0;
  logic prev_b  = 1'b0;
  int   low_run = 1000;
  logic log_a    [0:127];
  logic log_b    [0:127];
  logic log_t    [0:127];
  logic log_busy [0:127];

  task automatic chk(input string nm, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %b want %b", nm, cyc, got, exp);
    end
  endtask

  // Schedule view: after a start accepted in cycle s, cycle s+1+e is in carrier
  // period e/P at phase e%P; periods repeat as B burst then G gap.
  function automatic void st_at(input int c, output bit busy, output bit burst, output int ph);
    int e;
    int k;
    int span;
    busy  = 1'b0;
    burst = 1'b0;
    ph    = 0;
    if (m_act && c > m_s) begin
      e    = c - m_s - 1;
      k    = e / P;
      span = m_b + m_g;
      if (m_cont || k < span) begin
        busy  = 1'b1;
        ph    = e % P;
        burst = (k % span) < m_b;
      end
    end
  endfunction

  task automatic step();
    bit   sb, sbu, nb, nbu;
    int   sph, nph;
    logic ea, eb, et;
    @(posedge clk);
    st_at(cyc, sb, sbu, sph);
    if (rst || bus.stop) begin
      ea = 1'b0; eb = 1'b0; et = 1'b0;
      m_act = 1'b0;
    end else begin
      ea = sbu && (sph >= D) && (sph < H);
      eb = sbu && (sph >= H + D);
      et = sb && (sph == P - 1);
      if (bus.start && !sb && bus.burst_cycles != 0) begin
        m_act  = 1'b1;
        m_s    = cyc;
        m_b    = int'(bus.burst_cycles);
        m_g    = int'(bus.gap_cycles);
        m_cont = bus.continuous;
      end
    end
    st_at(cyc + 1, nb, nbu, nph);
    #1;
    cyc++;
    chk("ch_a", bus.ch_a, ea);
    chk("ch_b", bus.ch_b, eb);
    chk("carrier_tick", bus.carrier_tick, et);
    chk("busy", bus.busy, nb);
    chk("a_and_b", bus.ch_a & bus.ch_b, 1'b0);
    if ((bus.ch_a && !prev_a) || (bus.ch_b && !prev_b))
      chk("dead_time", low_run >= D, 1'b1);
    if (!bus.ch_a && !bus.ch_b) low_run++;
    else low_run = 0;
    prev_a = bus.ch_a;
    prev_b = bus.ch_b;
    if (cyc - base >= 0 && cyc - base < 128) begin
      log_a[cyc - base]    = bus.ch_a;
      log_b[cyc - base]    = bus.ch_b;
      log_t[cyc - base]    = bus.carrier_tick;
      log_busy[cyc - base] = bus.busy;
    end
  endtask

  task automatic go(input int bc, input int gc, input bit cn);
    bus.start        = 1'b1;
    bus.burst_cycles = W'(bc);
    bus.gap_cycles   = W'(gc);
    bus.continuous   = cn;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    logic seen;
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.stop         = 1'b0;
    bus.burst_cycles = '0;
    bus.gap_cycles   = '0;
    bus.continuous   = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Single burst 3/2, non-continuous
    base = cyc;
    go(3, 2, 1'b0);
    while (cyc - base < 60) step();
    chk("s1_busy1", log_busy[1], 1'b1);
    chk("s1_busy50", log_busy[50], 1'b1);
    chk("s1_busy51", log_busy[51], 1'b0);
    chk("s1_a2", log_a[2], 1'b0);
    chk("s1_a3", log_a[3], 1'b1);
    chk("s1_a6", log_a[6], 1'b1);
    chk("s1_a7", log_a[7], 1'b0);
    chk("s1_a26", log_a[26], 1'b1);
    chk("s1_b8", log_b[8], 1'b1);
    chk("s1_b11", log_b[11], 1'b1);
    chk("s1_b12", log_b[12], 1'b0);
    chk("s1_b31", log_b[31], 1'b1);
    chk("s1_t10", log_t[10], 1'b0);
    chk("s1_t11", log_t[11], 1'b1);
    chk("s1_t51", log_t[51], 1'b1);

    // Continuous, stopped at cycle 60
    base = cyc;
    go(3, 2, 1'b1);
    while (cyc - base < 60) step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    repeat (20) step();
    chk("s2_a52", log_a[52], 1'b0);
    chk("s2_a53", log_a[53], 1'b1);
    chk("s2_busy60", log_busy[60], 1'b1);
    chk("s2_busy61", log_busy[61], 1'b0);
    chk("s2_b61", log_b[61], 1'b0);
    chk("s2_busy80", log_busy[80], 1'b0);

    // Zero-length burst request is ignored
    go(0, 2, 1'b0);
    seen = 1'b0;
    repeat (100) begin
      step();
      seen = seen | bus.busy | bus.ch_a | bus.ch_b;
    end
    chk("s3_activity", seen, 1'b0);

    // Reset mid-burst, restart at 20
    base = cyc;
    go(3, 2, 1'b0);
    while (cyc - base < 15) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    while (cyc - base < 20) step();
    go(3, 2, 1'b0);
    while (cyc - base < 30) step();
    chk("s4_busy15", log_busy[15], 1'b1);
    chk("s4_busy16", log_busy[16], 1'b0);
    chk("s4_a16", log_a[16], 1'b0);
    chk("s4_a22", log_a[22], 1'b0);
    chk("s4_a23", log_a[23], 1'b1);
    repeat (60) step();

    // Start while busy must not disturb the running burst
    base = cyc;
    go(3, 2, 1'b0);
    while (cyc - base < 5) step();
    go(1, 0, 1'b1);
    while (cyc - base < 60) step();
    chk("s5_a23", log_a[23], 1'b1);
    chk("s5_b31", log_b[31], 1'b1);
    chk("s5_busy50", log_busy[50], 1'b1);
    chk("s5_busy51", log_busy[51], 1'b0);
    chk("s5_t51", log_t[51], 1'b1);

    // Random start/stop/reset traffic
    base = -100000;
    for (int i = 0; i < 10000; i++) begin
      rst              = ($urandom_range(0, 1999) == 0);
      bus.stop         = ($urandom_range(0, 299) == 0);
      bus.start        = ($urandom_range(0, 39) == 0);
      bus.burst_cycles = W'($urandom_range(0, 4));
      bus.gap_cycles   = W'($urandom_range(0, 3));
      bus.continuous   = 1'($urandom_range(0, 1));
      step();
    end
    rst       = 1'b0;
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/us_burst_driver.md
Name: us_burst_driver

Overview:
- Generates the ultrasonic carrier bursts for one Pmod US speaker channel pair. It drives the complementary half-bridge inputs ch_a/ch_b with enforced dead time.
- Replaces the free-running timer/toggle stage: it takes start/stop commands from upstream control logic and produces gated, cycle-counted bursts.
- Top level fans ch_a/ch_b out to ch1..ch3 and to the LED.

Parameters:
- PERIOD, 675, clocks per carrier period (27 MHz / 40 kHz).
- HALF, 337, clocks of the positive half (phase 0..HALF-1).
- DEAD, 14, dead-time clocks at the start of each half (~0.5 us).
- CNT_W, 16, width of the burst/gap cycle counts.

Ports:
- clk  in  1  system clock, 27 MHz.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request; latches burst_cycles, gap_cycles, continuous.
- stop  in  1  abort request, takes effect immediately.
- burst_cycles  in  CNT_W  carrier periods per burst.
- gap_cycles  in  CNT_W  silent carrier periods after each burst.
- continuous  in  1  repeat burst+gap until stop.
- busy  out  1  high whenever state != IDLE.
- carrier_tick  out  1  one-cycle pulse on each phase wrap PERIOD-1 -> 0 while busy.
- ch_a  out  1  high-side drive, positive half.
- ch_b  out  1  high-side drive, negative half.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- rst: state=IDLE, phase=0, all counters and latched values 0. busy, carrier_tick, ch_a, ch_b are all 0.
- Priority: rst > stop > start.
- FSM states: IDLE, BURST, GAP.
- IDLE:
  - start=1 with burst_cycles != 0 at edge t: latch the inputs; state=BURST and phase=0 at t+1.
  - start with burst_cycles == 0: ignored, no busy pulse.
- BURST:
  - phase counts 0..PERIOD-1 and wraps; each wrap decrements the remaining-burst count.
  - On the wrap that completes the last period: go to GAP if gap != 0. Otherwise go to BURST again if continuous, else IDLE.
- GAP:
  - phase keeps counting; outputs stay low.
  - After gap_cycles wraps: go to BURST (counts reloaded from the latches) if continuous, else IDLE.
- Output equations, registered with 1-cycle latency:
  - ch_a(t+1) = (state(t)==BURST) && DEAD <= phase(t) < HALF.
  - ch_b(t+1) = (state(t)==BURST) && HALF+DEAD <= phase(t) < PERIOD.
  - ch_a and ch_b are never both 1. Each half has exactly DEAD low clocks before its drive.
- stop=1 at t: state=IDLE, phase=0, ch_a=ch_b=busy=0 from t+1. This applies mid-pulse and mid-gap.
- start while busy: ignored, latched values unchanged. start and stop in the same cycle: stop wins.
- The last ch_b pulse of a burst may extend 1 clock into GAP (registered latency). This is expected.
- Elaboration-time checks:
  - 0 < DEAD < HALF
  - DEAD < PERIOD-HALF
  - PERIOD < 2^$clog2(PERIOD+1)

Decomposition:
- Package us_pkg: state enum {IDLE, BURST, GAP}; default constants US_PERIOD_27M=675, US_HALF_27M=337, US_DEAD_27M=14.
- Sub-module us_carrier_phase:
  - Inputs: clk, rst, run.
  - Outputs: phase, wrap.
  - Holds phase at 0 while run=0.
- The FSM, counters and output registers live in us_burst_driver.

Test Plan:
- Params PERIOD=10, HALF=5, DEAD=1. burst=3, gap=2, continuous=0, start at cycle 0 -> expected response:
  - busy high cycles 1..50.
  - ch_a high cycles 3-6, 13-16, 23-26; ch_b high cycles 8-11, 18-21, 28-31.
  - carrier_tick pulses at cycles 11, 21, 31, 41, 51.
- Same burst with continuous=1 -> second burst's ch_a high at cycles 53-56; runs indefinitely. stop at cycle 60 -> ch_b, busy=0 at 61 and stay 0.
- burst_cycles=0 start -> busy, ch_a, ch_b remain 0 for 100 cycles.
- Bus checks over a 10k-cycle random start/stop run:
  - ch_a & ch_b is never 1.
  - Every ch_a/ch_b rising edge is preceded by at least DEAD cycles with both outputs low.
- rst asserted mid-burst (cycle 15) -> all outputs 0 at 16; state IDLE; a new start at 20 produces ch_a at 23.
- start pulse at cycle 5 during an active burst -> ignored; burst length and timing are identical to the first scenario.
